// File: rtl/multiband_frequency_analyzer.sv
// Half-period classifier: measures ticks between input edges, bins them into up to four bands.
// Define MULTIBAND_FREQUENCY_ANALYZER_SYNC_EN to pass sample_data through a 2-flop synchroniser.
module multiband_frequency_analyzer #(
   parameter int unsigned BANDS           = 2,
   parameter int unsigned FREQUENCY0      = 9000,
   parameter int unsigned FREQUENCY1      = 11000,
   parameter int unsigned FREQUENCY2      = 13000,
   parameter int unsigned FREQUENCY3      = 15000,
   parameter int unsigned DEVIATION0      = 10,
   parameter int unsigned DEVIATION1      = 10,
   parameter int unsigned DEVIATION2      = 10,
   parameter int unsigned DEVIATION3      = 10,
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned ACC_WIDTH       = 32,
   parameter int unsigned HIT_WIDTH       = 16,
   parameter int unsigned TIMEOUT_TICKS   = 65535
) (
   input  logic                         clock,
   input  logic                         clear,
   input  logic                         sample_data,
   input  logic                         enable,
   input  logic                         snapshot,
   output logic [BANDS*ACC_WIDTH-1:0]   band_value,
   output logic [BANDS*HIT_WIDTH-1:0]   band_hits,
   output logic                         band_valid,
   output logic [1:0]                   band_index,
   output logic                         band_miss,
   output logic                         timeout
);

   localparam int unsigned CW   = $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned SUMW = ((ACC_WIDTH > CW) ? ACC_WIDTH : CW) + 1;
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT_TICKS);

   localparam int unsigned PER0 = CLOCK_FREQUENCY / (2 * FREQUENCY0);
   localparam int unsigned PER1 = CLOCK_FREQUENCY / (2 * FREQUENCY1);
   localparam int unsigned PER2 = CLOCK_FREQUENCY / (2 * FREQUENCY2);
   localparam int unsigned PER3 = CLOCK_FREQUENCY / (2 * FREQUENCY3);
   localparam int unsigned DEV0 = PER0 * DEVIATION0 / 100;
   localparam int unsigned DEV1 = PER1 * DEVIATION1 / 100;
   localparam int unsigned DEV2 = PER2 * DEVIATION2 / 100;
   localparam int unsigned DEV3 = PER3 * DEVIATION3 / 100;
   localparam int unsigned LO0 = PER0 - DEV0;
   localparam int unsigned LO1 = PER1 - DEV1;
   localparam int unsigned LO2 = PER2 - DEV2;
   localparam int unsigned LO3 = PER3 - DEV3;
   localparam int unsigned HI0 = PER0 + DEV0;
   localparam int unsigned HI1 = PER1 + DEV1;
   localparam int unsigned HI2 = PER2 + DEV2;
   localparam int unsigned HI3 = PER3 + DEV3;

   typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

   state_t                 state_q, state_d;
   logic                   sample_s;
   logic                   level_q;
   logic                   edge_det;
   logic [CW-1:0]          count_q, count_d;
   logic                   classify;
   logic                   expire;
   logic [31:0]            len;
   logic [3:0]             match;
   logic                   hit_any;
   logic [1:0]             hit_idx;
   logic [ACC_WIDTH-1:0]   acc_q [BANDS];
   logic [ACC_WIDTH-1:0]   acc_d [BANDS];
   logic [HIT_WIDTH-1:0]   hits_q [BANDS];
   logic [HIT_WIDTH-1:0]   hits_d [BANDS];
   logic [ACC_WIDTH-1:0]   acc_base;
   logic [HIT_WIDTH-1:0]   hits_base;
   logic [SUMW-1:0]        acc_sum;
   logic [BANDS*ACC_WIDTH-1:0] value_q;
   logic [BANDS*HIT_WIDTH-1:0] hits_out_q;
   logic                   valid_q;
   logic                   miss_q;
   logic [1:0]             index_q;
   logic                   timeout_q;

`ifdef MULTIBAND_FREQUENCY_ANALYZER_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clock) begin
      if (!clear) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sample_data;
         sync2_q <= sync1_q;
      end
   end

   assign sample_s = sync2_q;
`else
   assign sample_s = sample_data;
`endif

   // level_q follows the input every cycle, so it is the reference level when arming
   assign edge_det = (sample_s != level_q);

   always_ff @(posedge clock) begin
      if (!clear) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ARMED;
            ARMED:   if (edge_det) state_d = MEASURE;
            MEASURE: if (!edge_det && count_q == TIMEOUT_CNT) state_d = ARMED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      count_d  = '0;
      classify = 1'b0;
      expire   = 1'b0;
      if (enable) begin
         case (state_q)
            ARMED: if (edge_det) count_d = CW'(1);
            MEASURE: begin
               if (edge_det) begin
                  classify = 1'b1;
                  count_d  = CW'(1);
               end else if (count_q == TIMEOUT_CNT) begin
                  expire = 1'b1;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Lowest band index wins on overlap
   always_comb begin
      len      = 32'(count_q);
      match[0] = (BANDS > 0) && (len >= LO0) && (len <= HI0);
      match[1] = (BANDS > 1) && (len >= LO1) && (len <= HI1);
      match[2] = (BANDS > 2) && (len >= LO2) && (len <= HI2);
      match[3] = (BANDS > 3) && (len >= LO3) && (len <= HI3);
      hit_any  = |match;
      if      (match[0]) hit_idx = 2'd0;
      else if (match[1]) hit_idx = 2'd1;
      else if (match[2]) hit_idx = 2'd2;
      else               hit_idx = 2'd3;
   end

   // Snapshot zeroes the base first so a coincident classification starts the new totals
   always_comb begin
      acc_base  = '0;
      hits_base = '0;
      acc_sum   = '0;
      for (int unsigned k = 0; k < BANDS; k++) begin
         acc_base  = snapshot ? '0 : acc_q[k];
         hits_base = snapshot ? '0 : hits_q[k];
         acc_d[k]  = acc_base;
         hits_d[k] = hits_base;
         if (classify && hit_any && (hit_idx == 2'(k))) begin
            acc_sum = SUMW'(acc_base) + SUMW'(count_q);
            if (acc_sum[SUMW-1:ACC_WIDTH] != '0) acc_d[k] = '1;
            else                                 acc_d[k] = acc_sum[ACC_WIDTH-1:0];
            if (!(&hits_base)) hits_d[k] = hits_base + HIT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         level_q    <= 1'b0;
         count_q    <= '0;
         value_q    <= '0;
         hits_out_q <= '0;
         valid_q    <= 1'b0;
         miss_q     <= 1'b0;
         index_q    <= '0;
         timeout_q  <= 1'b0;
         for (int unsigned k = 0; k < BANDS; k++) begin
            acc_q[k]  <= '0;
            hits_q[k] <= '0;
         end
      end else begin
         level_q <= sample_s;
         count_q <= count_d;
         for (int unsigned k = 0; k < BANDS; k++) begin
            acc_q[k]  <= acc_d[k];
            hits_q[k] <= hits_d[k];
            if (snapshot) begin
               value_q[k*ACC_WIDTH +: ACC_WIDTH]    <= acc_q[k];
               hits_out_q[k*HIT_WIDTH +: HIT_WIDTH] <= hits_q[k];
            end
         end
         valid_q <= classify && hit_any;
         miss_q  <= classify && !hit_any;
         if (classify && hit_any) index_q <= hit_idx;
         if (expire)        timeout_q <= 1'b1;
         else if (snapshot) timeout_q <= 1'b0;
      end
   end

   assign band_value = value_q;
   assign band_hits  = hits_out_q;
   assign band_valid = valid_q;
   assign band_index = index_q;
   assign band_miss  = miss_q;
   assign timeout    = timeout_q;

endmodule

// File: doc/multiband_frequency_analyzer.md
# multiband_frequency_analyzer

- Measures the half-period length of a single-bit input (`sample_data`) in clock ticks.
- Classifies each half-period into one of up to four configurable frequency bands and accumulates ticks and hit counts per band.
- Adds four things the two-band analyzer it succeeds lacks: atomic snapshot/clear readout, saturation, timeout detection and a per-edge result strobe.
- Sits between the demodulator's sampled bit stream and the register/readout logic.

## Interface

Parameters:
- `BANDS`, 2, number of active bands, 1..4.
- `FREQUENCY0`..`FREQUENCY3`, 9000 / 11000 / 13000 / 15000, band centre frequencies in Hz.
- `DEVIATION0`..`DEVIATION3`, 10, band tolerance in percent.
- `CLOCK_FREQUENCY`, 50000000, clock rate in Hz.
- `ACC_WIDTH`, 32, width of each tick accumulator.
- `HIT_WIDTH`, 16, width of each hit counter.
- `TIMEOUT_TICKS`, 65535, longest half-period accepted.

Ports (clock and reset first):
- `clock` in 1: single clock; all logic on its rising edge.
- `clear` in 1: reset, synchronous, active-low.
- `sample_data` in 1: sampled input bit.
- `enable` in 1: measurement enable.
- `snapshot` in 1: one-cycle request to latch accumulators to the outputs and zero them.
- `band_value` out `BANDS*ACC_WIDTH`: latched tick totals; band k occupies bits `[k*ACC_WIDTH +: ACC_WIDTH]`.
- `band_hits` out `BANDS*HIT_WIDTH`: latched hit counts, packed the same way.
- `band_valid` out 1: one-cycle strobe, a half-period was classified.
- `band_index` out 2: band of the last classification; meaningful only with `band_valid`.
- `band_miss` out 1: one-cycle strobe, a half-period matched no band.
- `timeout` out 1: sticky; cleared by `snapshot` or reset.

## Operation

Band limits are elaboration-time constants:
- `T_k = CLOCK_FREQUENCY / (2*FREQUENCYk)`, `D_k = T_k*DEVIATIONk / 100`, integer truncation.
- Band k matches L when `T_k - D_k <= L <= T_k + D_k`.
- If bands overlap, the lowest index wins.
- Bands with index >= `BANDS` never match.

State machine:
- **IDLE**
  - Entered from reset, and in the cycle `enable` is low from any state; the partial measurement is discarded.
  - Moves to ARMED in the cycle `enable` is high; the current `sample_data` is registered as the reference level.
- **ARMED**
  - Waits for the first edge (`sample_data` != reference level). That edge starts the first measurement and its preceding partial interval is not counted.
  - On that edge, moves to MEASURE with the period counter set to 1.
- **MEASURE**
  - The period counter increments every cycle.
  - On an edge: L = counter value, the half-period is classified, the counter reloads to 1 and the state stays MEASURE.
  - L equals the number of cycles between the two edge-detect cycles.
  - If the counter reaches `TIMEOUT_TICKS` without an edge: `timeout` is set, the measurement is discarded and the state moves to ARMED.

On a classified edge:
- **Match in band k:** `acc_k += L` and `hits_k += 1`; both saturate at all-ones and never wrap. `band_valid` = 1 and `band_index` = k.
- **No match:** no accumulator changes and `band_miss` = 1.

Snapshot:
- In the cycle `snapshot` is high, `band_value`/`band_hits` take the accumulator values as they were before that cycle's update.
- In the same cycle all accumulators and hit counters clear and `timeout` clears.
- If a classification lands in the same cycle, its contribution becomes the new accumulator content; nothing is lost and nothing is double-counted.
- `snapshot` is honoured in every state, including while `enable` is low.

## Timing

- Edge detect in cycle t: `band_valid`/`band_miss` and the accumulator update are visible from cycle t+1, so classification latency is 1 cycle.
- `snapshot` sampled in cycle t: outputs are updated from cycle t+1.
- `timeout` rises in the cycle after the counter reaches `TIMEOUT_TICKS`.
- Reset values (`clear` low at a rising edge): every output 0, all accumulators 0, state IDLE. A reset mid-measurement discards it.
- `enable` low mid-period: no classification for that period, and no strobe.

## Configuration

- Macro: `MULTIBAND_FREQUENCY_ANALYZER_SYNC_EN`.
- **Defined:** `sample_data` passes through a 2-flop synchroniser before edge detection. This adds 2 cycles to the edge-to-strobe latency; measured lengths are unchanged.
- **Undefined:** `sample_data` is used directly, for callers that already provide a synchronous signal.

## Test plan

With defaults (bands 0 and 1 only): band 0 accepts L 2500..3054, band 1 accepts L 2045..2499.

1. **Band 0 square wave:** reset, `enable`=1, square wave with 2777-cycle half-periods, 11 edges, then `snapshot` → `band_value[0]`=27770, `band_hits[0]`=10, band 1 = 0, 10 `band_valid` strobes with `band_index`=0.
2. **Band 1 square wave:** 2272-cycle half-periods, 6 edges, `snapshot` → `band_value[1]`=11360, `band_hits[1]`=5.
3. **Miss:** 1500-cycle half-periods, 4 edges → 3 `band_miss` strobes, accumulators stay 0.
4. **Timeout:** hold `sample_data` constant for 70000 cycles after arming → `timeout`=1 at cycle 65536 of MEASURE, no strobe; `snapshot` → `timeout`=0.
5. **Snapshot/classification collision:** `snapshot` asserted in the same cycle as a band-0 edge with L=2777 after 3 prior hits → `band_hits[0]`=3 and `band_value[0]`=8331; a second `snapshot` → 1 / 2777.
6. **Saturation:** run with `ACC_WIDTH`=16, then `clear` low mid-period → `band_value` saturates at 65535 (no wrap), then every output reads 0.
